dap_response_packer: RTL and testbench

Collects the response bytes written by a DAP command worker into a packet buffer and streams the finished packet to the USB endpoint with full valid/ready handshake. Sits between the command worker outputs (unstalled valid/data byte stream plus a done indication) and the endpoint TX interface, and is the reading end for every worker's response writer.

---
 rtl/dap_pkg.sv | 13 +
 rtl/dap_resp_ram.sv | 23 ++
 rtl/dap_response_packer.sv | 160 ++++++++++++++++
 tb/tb_dap_response_packer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dap_pkg.sv
// Shared DAP definitions: packet size, invalid-command ID and the packer state encoding.
package dap_pkg;

  localparam int        DAP_PACKET_SIZE = 64;
  localparam logic [7:0] DAP_ID_INVALID = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_SEND    = 2'd2
  } packer_state_t;

endpackage

// File: rtl/dap_resp_ram.sv
// Simple dual-port response buffer: one write port, registered read port, no reset.
module dap_resp_ram #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [DEPTH];

  // Read data holds while re is low, which lets the packer stall without a skid copy.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dap_response_packer.sv
// Buffers a DAP worker's response bytes and streams them to the USB endpoint.
// Optional feature macro: DAP_RESP_PAD_EN pads every packet to BUF_DEPTH bytes with 0x00.
module dap_response_packer
  import dap_pkg::*;
#(
  parameter  int BUF_DEPTH = DAP_PACKET_SIZE,
  localparam int ADDR_W    = $clog2(BUF_DEPTH)
) (
  input  logic            hclk,
  input  logic            hresetn,
  input  logic            start,
  input  logic            wr_tvalid,
  input  logic [7:0]      wr_tdata,
  input  logic            cmd_done,
  output logic            pkt_tvalid,
  input  logic            pkt_tready,
  output logic [7:0]      pkt_tdata,
  output logic            pkt_tlast,
  output logic [ADDR_W:0] pkt_len,
  output logic            overflow,
  output logic            busy,
  output logic            sent
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(BUF_DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] CNT_ZERO  = '0;

  packer_state_t state, next_state;

  logic [ADDR_W:0] wr_count;
  logic [ADDR_W:0] rd_count;
  logic [ADDR_W:0] out_idx;
  logic [ADDR_W:0] total_len;
  logic            out_valid;
  logic            out_pad;

  logic accept_start;
  logic byte_store;
  logic overflow_hit;
  logic finish_collect;
  logic zero_len;
  logic issue;
  logic beat_done;
  logic last_beat;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

`ifdef DAP_RESP_PAD_EN
  assign total_len = DEPTH_CNT;
`else
  assign total_len = pkt_len;
`endif

  assign busy       = (state != ST_IDLE);
  assign pkt_tvalid = out_valid;
  assign pkt_tdata  = (out_valid && !out_pad) ? ram_rdata : 8'h00;
  assign pkt_tlast  = out_valid && (out_idx == (total_len - CNT_ONE));

  always_ff @(posedge hclk) begin
    if (!hresetn) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state     = state;
    accept_start   = 1'b0;
    byte_store     = 1'b0;
    overflow_hit   = 1'b0;
    finish_collect = 1'b0;
    zero_len       = 1'b0;
    issue          = 1'b0;
    beat_done      = 1'b0;
    last_beat      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          next_state   = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (wr_tvalid) begin
          if (wr_count == DEPTH_CNT) overflow_hit = 1'b1;
          else                       byte_store   = 1'b1;
        end
        if (cmd_done) begin
          finish_collect = 1'b1;
          zero_len       = (wr_count == CNT_ZERO) && !wr_tvalid;
          next_state     = ST_SEND;
        end
      end
      ST_SEND: begin
        beat_done = out_valid && pkt_tready;
        last_beat = beat_done && pkt_tlast;
        // Fetch the next byte whenever the output slot is empty or being drained.
        issue = (!out_valid || pkt_tready) && (rd_count < total_len);
        if (last_beat) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // An empty response still reports one byte: the invalid-command ID at address 0.
  assign ram_we    = byte_store || zero_len;
  assign ram_waddr = zero_len ? '0 : wr_count[ADDR_W-1:0];
  assign ram_wdata = zero_len ? DAP_ID_INVALID : wr_tdata;

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      wr_count  <= '0;
      rd_count  <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      out_pad   <= 1'b0;
      pkt_len   <= '0;
      overflow  <= 1'b0;
      sent      <= 1'b0;
    end else begin
      sent <= last_beat;
      if (accept_start) begin
        wr_count <= '0;
        overflow <= 1'b0;
      end
      if (byte_store)   wr_count <= wr_count + CNT_ONE;
      if (overflow_hit) overflow <= 1'b1;
      if (finish_collect) begin
        rd_count <= '0;
        if (zero_len)        pkt_len <= CNT_ONE;
        else if (byte_store) pkt_len <= wr_count + CNT_ONE;
        else                 pkt_len <= wr_count;
      end
      if (issue) begin
        rd_count  <= rd_count + CNT_ONE;
        out_idx   <= rd_count;
        out_pad   <= (rd_count >= pkt_len);
        out_valid <= 1'b1;
      end else if (beat_done) begin
        out_valid <= 1'b0;
      end
    end
  end

  dap_resp_ram #(
    .DEPTH  (BUF_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (hclk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (issue),
    .raddr (rd_count[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_dap_response_packer.sv
// Directed bench for dap_response_packer; expected packets come from a small byte-queue model.
// Honours DAP_RESP_PAD_EN when building the expected packet.
module tb_dap_response_packer;

  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);

  typedef logic [7:0] byteQ_t[$];

  logic        hclk       = 1'b0;
  logic        hresetn    = 1'b0;
  logic        start      = 1'b0;
  logic        wr_tvalid  = 1'b0;
  logic [7:0]  wr_tdata   = 8'h00;
  logic        cmd_done   = 1'b0;
  logic        pkt_tready = 1'b0;
  logic        pkt_tvalid;
  logic [7:0]  pkt_tdata;
  logic        pkt_tlast;
  logic [AW:0] pkt_len;
  logic        overflow;
  logic        busy;
  logic        sent;

  int vectorCount     = 0;
  int miscompareCount = 0;

  always #5 hclk = ~hclk;

  dap_response_packer #(.BUF_DEPTH(DEPTH)) dut (
    .hclk       (hclk),
    .hresetn    (hresetn),
    .start      (start),
    .wr_tvalid  (wr_tvalid),
    .wr_tdata   (wr_tdata),
    .cmd_done   (cmd_done),
    .pkt_tvalid (pkt_tvalid),
    .pkt_tready (pkt_tready),
    .pkt_tdata  (pkt_tdata),
    .pkt_tlast  (pkt_tlast),
    .pkt_len    (pkt_len),
    .overflow   (overflow),
    .busy       (busy),
    .sent       (sent)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Offers a stray byte in IDLE, starts a response, writes the bytes, then raises cmd_done.
  // Returns at the falling edge just after cmd_done was sampled.
  task automatic applyStimulus(input byteQ_t wrBytes, input bit doneWithLast);
    @(negedge hclk);
    wr_tvalid = 1'b1;
    wr_tdata  = 8'hA5;
    cmd_done  = 1'b1;
    @(negedge hclk);
    wr_tvalid = 1'b0;
    cmd_done  = 1'b0;
    start     = 1'b1;
    @(negedge hclk);
    start = 1'b0;
    checkOutput("busy after start", 32'(busy), 32'd1);
    checkOutput("overflow after start", 32'(overflow), 32'd0);
    foreach (wrBytes[i]) begin
      wr_tvalid = 1'b1;
      wr_tdata  = wrBytes[i];
      if (doneWithLast && (i == wrBytes.size() - 1)) cmd_done = 1'b1;
      @(negedge hclk);
    end
    wr_tvalid = 1'b0;
    if (!cmd_done) begin
      cmd_done = 1'b1;
      @(negedge hclk);
    end
    cmd_done = 1'b0;
  endtask

  task automatic receivePacket(input string name, input byteQ_t expBytes, input bit randReady);
    int         beats   = 0;
    int         cycles  = 0;
    bit         done    = 1'b0;
    bit         stalled = 1'b0;
    logic [7:0] heldData = 8'h00;
    logic       heldLast = 1'b0;
    while (!done && cycles < 1000) begin
      @(negedge hclk);
      cycles++;
      if (cycles == 1) checkOutput({name, " valid after 2 cycles"}, 32'(pkt_tvalid), 32'd1);
      else             checkOutput({name, " valid steady"}, 32'(pkt_tvalid), 32'd1);
      if (stalled) begin
        checkOutput({name, " held data"}, 32'(pkt_tdata), 32'(heldData));
        checkOutput({name, " held last"}, 32'(pkt_tlast), 32'(heldLast));
      end
      pkt_tready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pkt_tvalid && pkt_tready) begin
        if (beats < expBytes.size()) begin
          checkOutput($sformatf("%s byte %0d", name, beats), 32'(pkt_tdata), 32'(expBytes[beats]));
          checkOutput($sformatf("%s tlast %0d", name, beats), 32'(pkt_tlast),
                      32'(beats == expBytes.size() - 1));
        end else begin
          checkOutput({name, " extra beat"}, 32'(beats), 32'(expBytes.size() - 1));
        end
        done    = pkt_tlast;
        stalled = 1'b0;
        beats++;
      end else if (pkt_tvalid) begin
        stalled  = 1'b1;
        heldData = pkt_tdata;
        heldLast = pkt_tlast;
      end
    end
    checkOutput({name, " completed"}, 32'(done), 32'd1);
    checkOutput({name, " beat count"}, 32'(beats), 32'(expBytes.size()));
    @(negedge hclk);
    pkt_tready = 1'b0;
    checkOutput({name, " sent pulse"}, 32'(sent), 32'd1);
    checkOutput({name, " valid after last"}, 32'(pkt_tvalid), 32'd0);
    checkOutput({name, " busy after last"}, 32'(busy), 32'd0);
    @(negedge hclk);
    checkOutput({name, " sent once"}, 32'(sent), 32'd0);
  endtask

  task automatic runPacket(input string name, input byteQ_t wrBytes, input bit doneWithLast,
                           input bit randReady);
    byteQ_t expBytes;
    int     expLen;
    applyStimulus(wrBytes, doneWithLast);
    if (wrBytes.size() == 0) expBytes.push_back(8'hFF);
    else for (int i = 0; i < wrBytes.size() && i < DEPTH; i++) expBytes.push_back(wrBytes[i]);
    expLen = expBytes.size();
`ifdef DAP_RESP_PAD_EN
    while (expBytes.size() < DEPTH) expBytes.push_back(8'h00);
`endif
    checkOutput({name, " pkt_len"}, 32'(pkt_len), 32'(expLen));
    checkOutput({name, " overflow"}, 32'(overflow), 32'(wrBytes.size() > DEPTH));
    checkOutput({name, " valid 1 cycle after done"}, 32'(pkt_tvalid), 32'd0);
    receivePacket(name, expBytes, randReady);
  endtask

  initial begin
    byteQ_t q;
    int     beats;
    int     cycles;

    repeat (3) @(negedge hclk);
    checkOutput("reset pkt_tvalid", 32'(pkt_tvalid), 32'd0);
    checkOutput("reset pkt_tdata", 32'(pkt_tdata), 32'd0);
    checkOutput("reset pkt_tlast", 32'(pkt_tlast), 32'd0);
    checkOutput("reset pkt_len", 32'(pkt_len), 32'd0);
    checkOutput("reset overflow", 32'(overflow), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset sent", 32'(sent), 32'd0);
    hresetn = 1'b1;

    q = '{8'h09, 8'h00};
    runPacket("two byte", q, 1'b0, 1'b0);

    q.delete();
    runPacket("zero len", q, 1'b0, 1'b0);

    q = '{8'h11, 8'h22, 8'h33};
    runPacket("done with last", q, 1'b1, 1'b0);

    q.delete();
    for (int i = 0; i < 70; i++) q.push_back(8'(i * 3 + 1));
    runPacket("overflow", q, 1'b1, 1'b0);

    q.delete();
    for (int i = 0; i < 10; i++) q.push_back(8'(8'hC0 + i));
    runPacket("stall", q, 1'b0, 1'b1);

    // Reset in the middle of SEND after three accepted beats.
    q.delete();
    for (int i = 0; i < 10; i++) q.push_back(8'(8'h50 + i));
    applyStimulus(q, 1'b0);
    pkt_tready = 1'b1;
    beats  = 0;
    cycles = 0;
    while (beats < 3 && cycles < 50) begin
      @(negedge hclk);
      cycles++;
      if (pkt_tvalid) beats++;
    end
    checkOutput("reset mid-send beats", 32'(beats), 32'd3);
    @(negedge hclk);
    hresetn    = 1'b0;
    pkt_tready = 1'b0;
    @(negedge hclk);
    checkOutput("mid-send reset valid", 32'(pkt_tvalid), 32'd0);
    checkOutput("mid-send reset busy", 32'(busy), 32'd0);
    checkOutput("mid-send reset sent", 32'(sent), 32'd0);
    hresetn = 1'b1;

    q = '{8'h01, 8'h02, 8'h03, 8'h04};
    runPacket("after reset", q, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
